unsat_clause_fifo: RTL and testbench
====================================

UNSAT_CLAUSE_FIFO -- requirements
Module: unsat_clause_fifo

Interface
REQ-001 Parameter NSAT, default 3, literals per clause.
REQ-002 Parameter LITERAL_ADDRESS_WIDTH, default 12, bits per literal address.
REQ-003 Parameter FIFO_DEPTH, default 16, entries; SHALL be a power of 2, minimum 2.
REQ-004 Derived widths: CW = NSAT*LITERAL_ADDRESS_WIDTH; AW = log2(FIFO_DEPTH).
REQ-005 Ports SHALL be, in this order:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- flush_i  in  1  discards all entries.
- push_i  in  1  write request from the clause evaluator (newly unsat clause).
- push_clause_i  in  CW  clause written on push.
- full_o  out  1  count == FIFO_DEPTH.
- pop_i  in  1  selector consumes head entry.
- empty_o  out  1  count == 0; feeds selector fifo_empty_i.
- last_o  out  1  count == 1; feeds selector write_disable_i logic.
- head_clause_o  out  CW  head entry, first-word-fall-through; feeds selector fifo_clause_i.
- count_o  out  AW+1  occupancy.
- clear_flags_i  in  1  clears sticky error flags.
- overflow_o  out  1  sticky: push dropped while full.
- underflow_o  out  1  sticky: pop while empty.

Function
REQ-006 Storage SHALL be a FIFO_DEPTH x CW register array with AW-bit write and read pointers that wrap from FIFO_DEPTH-1 to 0.
REQ-007 head_clause_o SHALL be combinational: mem[rd_ptr] when count_o != 0, all zeros when empty.
REQ-008 Push accepted iff push_i & (~full_o | pop_i); on accept, mem[wr_ptr] <= push_clause_i and wr_ptr increments.
REQ-009 Pop accepted iff pop_i & ~empty_o; on accept, rd_ptr increments.
REQ-010 count_o: +1 on accepted push only, -1 on accepted pop only, unchanged when both or neither are accepted.
REQ-011 Latency: a clause pushed into an empty FIFO SHALL appear on head_clause_o, with empty_o low, in the cycle after the push edge; there is no same-cycle bypass.
REQ-012 Push and pop while full: both accepted, count stays FIFO_DEPTH, full_o stays high, overflow_o not set.
REQ-013 Push and pop while empty: push accepted, pop ignored, count becomes 1, underflow_o set.
REQ-014 Push while full without pop: data dropped, pointers and count unchanged, overflow_o set.
REQ-015 Pop while empty without push: no state change except underflow_o set.
REQ-016 flush_i SHALL zero the pointers and count next cycle, overriding push/pop in the same cycle; sticky flags are unaffected.
REQ-017 clear_flags_i SHALL zero overflow_o and underflow_o next cycle; a flag-setting event in the same cycle wins (flag ends high).
REQ-018 Status outputs full_o, empty_o and last_o SHALL decode from the count register only, glitch-free, and be valid every cycle.
REQ-019 Array contents SHALL NOT be reset; only pointers, count and flags are reset.

Reset
REQ-020 While reset is high: pointers = 0, count_o = 0, empty_o = 1, full_o = 0, last_o = 0, overflow_o = 0, underflow_o = 0, head_clause_o = 0.
REQ-021 Reset SHALL override flush_i, push_i, pop_i and clear_flags_i; reset mid-stream discards all entries, and the first push after release is accepted normally.

Verification
REQ-022 Push A=0x000001002003 into empty -> next cycle empty_o=0, last_o=1, count_o=1, head=A; pop -> next cycle empty_o=1, head=0.
REQ-023 Push 16 distinct clauses (depth 16) -> full_o=1, count_o=16; 17th push -> overflow_o=1, count 16; 16 pops return clauses in order, exercising pointer wrap.
REQ-024 Full FIFO, push X + pop same cycle -> count stays 16, old head removed, X is last out, overflow_o=0.
REQ-025 Empty FIFO, push Y + pop same cycle -> count_o=1, head=Y next cycle, underflow_o=1; clear_flags_i -> underflow_o=0.
REQ-026 Count 5, flush_i + push_i same cycle -> count_o=0, empty_o=1, sticky flags unchanged.
REQ-027 Count 3, reset pulse mid-stream -> all REQ-020 values; next push accepted and appears at head.

Source files
------------

// File: rtl/unsat_clause_fifo.sv
// unsat_clause_fifo: first-word-fall-through FIFO of unsatisfied clauses with sticky overflow/underflow flags
module unsat_clause_fifo #(
    parameter int NSAT = 3,
    parameter int LITERAL_ADDRESS_WIDTH = 12,
    parameter int FIFO_DEPTH = 16,
    localparam int CW = NSAT * LITERAL_ADDRESS_WIDTH,
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [CW-1:0] push_clause_i,
    output logic          full_o,
    input  logic          pop_i,
    output logic          empty_o,
    output logic          last_o,
    output logic [CW-1:0] head_clause_o,
    output logic [AW:0]   count_o,
    input  logic          clear_flags_i,
    output logic          overflow_o,
    output logic          underflow_o
);
    logic [CW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push_ok, pop_ok;

    assign full_o        = count_o == (AW+1)'(FIFO_DEPTH);
    assign empty_o       = count_o == '0;
    assign last_o        = count_o == (AW+1)'(1);
    assign push_ok       = push_i & (~full_o | pop_i);
    assign pop_ok        = pop_i & ~empty_o;
    assign head_clause_o = empty_o ? '0 : mem[rd_ptr];

    always_ff @(posedge clk)
        if (push_ok && !flush_i && !reset) mem[wr_ptr] <= push_clause_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_o     <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (flush_i) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_o <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
                count_o <= (push_ok && !pop_ok) ? count_o + 1'b1 :
                           (pop_ok && !push_ok) ? count_o - 1'b1 : count_o;
            end
            // a same-cycle flag event beats clear_flags_i
            overflow_o  <= (push_i & full_o & ~pop_i) | (overflow_o & ~clear_flags_i);
            underflow_o <= (pop_i & empty_o) | (underflow_o & ~clear_flags_i);
        end
    end
endmodule

// File: tb/tb_unsat_clause_fifo.sv
// tb_unsat_clause_fifo: directed vectors against hand-computed FIFO behaviour at depth 16
module tb_unsat_clause_fifo;
    logic        clk = 1'b0;
    logic        reset, flush_i, push_i, pop_i, clear_flags_i;
    logic [35:0] push_clause_i, head_clause_o;
    logic        full_o, empty_o, last_o, overflow_o, underflow_o;
    logic [4:0]  count_o;
    int          vectors = 0;
    int          miscompares = 0;

    localparam logic [35:0] A = 36'h001002003;
    localparam logic [35:0] X = 36'h0ABCDEF12;
    localparam logic [35:0] Y = 36'h0777888999;
    localparam logic [35:0] Z = 36'h0DEADBEEF;
    localparam logic [35:0] W = 36'h012345678;
    localparam logic [35:0] V = 36'h0FEDCBA98;

    unsat_clause_fifo dut (
        .clk(clk), .reset(reset), .flush_i(flush_i), .push_i(push_i),
        .push_clause_i(push_clause_i), .full_o(full_o), .pop_i(pop_i),
        .empty_o(empty_o), .last_o(last_o), .head_clause_o(head_clause_o),
        .count_o(count_o), .clear_flags_i(clear_flags_i),
        .overflow_o(overflow_o), .underflow_o(underflow_o)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] cl(input int i);
        return {12'(i + 1), 12'(i * 3 + 7), 12'(12'hA00 + i)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic ps, input logic [35:0] d, input logic pp,
                         input logic fl, input logic cf);
        push_i = ps; push_clause_i = d; pop_i = pp; flush_i = fl; clear_flags_i = cf;
        @(posedge clk); #1;
        push_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0; clear_flags_i = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " count"}, count_o, 0);
        chk({tag, " empty"}, empty_o, 1);
        chk({tag, " full"}, full_o, 0);
        chk({tag, " last"}, last_o, 0);
        chk({tag, " ovf"}, overflow_o, 0);
        chk({tag, " unf"}, underflow_o, 0);
        chk({tag, " head"}, head_clause_o, 0);
    endtask

    initial begin
        reset = 1'b1; flush_i = 1'b0; push_i = 1'b0; pop_i = 1'b0;
        clear_flags_i = 1'b0; push_clause_i = '0;
        repeat (2) @(posedge clk);
        #1 chk_reset_state("rst");
        reset = 1'b0;
        // single push then pop
        drive(1, A, 0, 0, 0);
        chk("a empty", empty_o, 0);
        chk("a last", last_o, 1);
        chk("a count", count_o, 1);
        chk("a head", head_clause_o, A);
        drive(0, 0, 1, 0, 0);
        chk("a pop empty", empty_o, 1);
        chk("a pop head", head_clause_o, 0);
        chk("a pop unf", underflow_o, 0);
        // fill, overflow, full push+pop
        for (int i = 0; i < 16; i++) drive(1, cl(i), 0, 0, 0);
        chk("fill full", full_o, 1);
        chk("fill count", count_o, 16);
        chk("fill last", last_o, 0);
        chk("fill head", head_clause_o, cl(0));
        drive(1, 36'hFFFFFFFFF, 0, 0, 0);
        chk("ovf flag", overflow_o, 1);
        chk("ovf count", count_o, 16);
        chk("ovf head", head_clause_o, cl(0));
        drive(0, 0, 0, 0, 1);
        chk("ovf clear", overflow_o, 0);
        drive(1, X, 1, 0, 0);
        chk("fullpp count", count_o, 16);
        chk("fullpp full", full_o, 1);
        chk("fullpp ovf", overflow_o, 0);
        chk("fullpp head", head_clause_o, cl(1));
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("drain %0d", i), head_clause_o, cl(i));
            drive(0, 0, 1, 0, 0);
        end
        chk("drain x", head_clause_o, X);
        chk("drain x last", last_o, 1);
        drive(0, 0, 1, 0, 0);
        chk("drain empty", empty_o, 1);
        chk("drain count", count_o, 0);
        chk("drain unf", underflow_o, 0);
        // empty push+pop, flag clear, clear-vs-event priority
        drive(1, Y, 1, 0, 0);
        chk("emptypp count", count_o, 1);
        chk("emptypp head", head_clause_o, Y);
        chk("emptypp unf", underflow_o, 1);
        drive(0, 0, 0, 0, 1);
        chk("unf clear", underflow_o, 0);
        drive(0, 0, 1, 0, 0);
        chk("y popped", empty_o, 1);
        drive(0, 0, 1, 0, 1);
        chk("clr vs event", underflow_o, 1);
        chk("unf count", count_o, 0);
        // flush beats push
        for (int i = 0; i < 5; i++) drive(1, cl(20 + i), 0, 0, 0);
        chk("pre flush count", count_o, 5);
        drive(1, Z, 0, 1, 0);
        chk("flush count", count_o, 0);
        chk("flush empty", empty_o, 1);
        chk("flush head", head_clause_o, 0);
        chk("flush unf", underflow_o, 1);
        chk("flush ovf", overflow_o, 0);
        drive(1, W, 0, 0, 0);
        chk("post flush head", head_clause_o, W);
        chk("post flush count", count_o, 1);
        // reset mid-stream overrides pending requests
        drive(1, cl(30), 0, 0, 0);
        drive(1, cl(31), 0, 0, 0);
        chk("pre rst count", count_o, 3);
        reset = 1'b1; push_i = 1'b1; push_clause_i = Z; pop_i = 1'b1; flush_i = 1'b1;
        @(posedge clk); #1;
        chk_reset_state("midrst");
        reset = 1'b0; push_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0;
        drive(1, V, 0, 0, 0);
        chk("post rst count", count_o, 1);
        chk("post rst head", head_clause_o, V);
        chk("post rst empty", empty_o, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
